// File: rtl/bram_operand_fetch_pkg.sv
// Shared definitions for the operand-fetch read path.
// Holds default widths and the fetch controller state encoding.
// No logic of its own.
package bram_operand_fetch_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// 2-entry FIFO with registered head; same-cycle push and pop keep the count unchanged.
// Latency: a pushed word is visible at the head the cycle after an empty-FIFO push.
// Backpressure: the writer throttles on count; a push into a full FIFO without a pop is dropped.
module fetch_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         head_vld,
    output logic [1:0]   count
);

    logic [W-1:0] tail_dat;
    logic         do_push;
    logic         do_pop;

    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign head_vld = (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_dat <= '0;
            tail_dat <= '0;
            count    <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head_dat <= push_dat;
                    else               tail_dat <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_dat <= tail_dat;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves; the word behind it (or the new one) moves up.
                    if (count == 2'd1) begin
                        head_dat <= push_dat;
                    end else begin
                        head_dat <= tail_dat;
                        tail_dat <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_operand_fetch.sv
// Walks a ROM address range and streams the words out as valid/ready beats.
// Latency: first beat valid two cycles after start is sampled; one beat per cycle after that.
// Backpressure: reads are issued only while buffered + in-flight words stay below two.
module bram_operand_fetch
    import bram_operand_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [ADDR_W:0]   m_index
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ADDR_W:0]   index;
    } beat_t;

    localparam logic [ADDR_W:0]   IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e    state;
    logic            armed;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] issued;
    logic [ADDR_W:0] pend_idx;
    logic            pend;
    logic [1:0]      count;
    logic            pop;
    logic            issue;
    logic            head_vld;
    beat_t           push_beat;
    beat_t           head_beat;

    assign pop   = head_vld && m_ready;
    // Occupancy after this cycle must leave room for the word now being read.
    assign issue = (state == ST_FETCH) &&
                   (({1'b0, count} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

    assign push_beat.data  = rom_data;
    assign push_beat.last  = (pend_idx == (len_q - IDX_ONE));
    assign push_beat.index = pend_idx;

    fetch_skid_fifo #(
        .W ($bits(beat_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pend),
        .push_dat (push_beat),
        .pop      (pop),
        .head_dat (head_beat),
        .head_vld (head_vld),
        .count    (count)
    );

    assign m_valid = head_vld;
    assign m_data  = head_beat.data;
    assign m_last  = head_beat.last;
    assign m_index = head_beat.index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            len_q    <= '0;
            issued   <= '0;
            pend_idx <= '0;
            pend     <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            pend <= issue;
            // A start level held through reset release must not launch a burst.
            if (!start) armed <= 1'b1;
            if (issue)  pend_idx <= issued;

            case (state)
                ST_IDLE: begin
                    if (start && armed) begin
                        len_q    <= len;
                        issued   <= '0;
                        rom_addr <= base_addr;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        issued <= issued + IDX_ONE;
                        if ((issued + IDX_ONE) == len_q) state <= ST_DRAIN;
                        else                              rom_addr <= rom_addr + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (!pend && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_operand_fetch.sv
// Directed bench for bram_operand_fetch with a synchronous-read ROM model.
module tb_bram_operand_fetch;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic [ADDR_W:0]   m_index;

    logic [DATA_W-1:0] rom [8];
    logic [ADDR_W-1:0] addr_log [16];
    int                nrec;
    int                checks = 0;
    int                errors = 0;

    bram_operand_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_index   (m_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0 pattern plus a 5-cycle stall; mode 2: ready high, start re-pulsed mid-burst
    task automatic run_burst(input logic [2:0] b, input logic [3:0] l, input int mode, input string nm);
        int          k;
        int          first_vld;
        int          last_hs;
        int          done_cyc;
        int          exp_done;
        logic        stalled;
        logic [31:0] hold_dat;
        logic [3:0]  hold_idx;
        logic [2:0]  a;
        k = 0; first_vld = -1; last_hs = -1; done_cyc = -1;
        stalled = 1'b0; hold_dat = '0; hold_idx = '0;
        nrec = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l; m_ready = (mode != 1);
        @(posedge clk); #1;
        start = 1'b0; base_addr = ~b; len = 4'd3;
        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            if (mode == 1) m_ready = (cyc >= 6 && cyc <= 10) ? 1'b0 : (cyc % 3 == 0);
            if (mode == 2) begin
                start = (cyc == 3);
                len = 4'd2;
                base_addr = 3'd5;
            end
            @(negedge clk);
            if (nrec < 16 && (nrec == 0 || addr_log[nrec-1] != rom_addr)) begin
                addr_log[nrec] = rom_addr;
                nrec++;
            end
            if (cyc == 0) check({nm, "_busy_first"}, busy, (l != 0));
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (stalled) begin
                check($sformatf("%s_stall_dat%0d", nm, cyc), m_data, hold_dat);
                check($sformatf("%s_stall_idx%0d", nm, cyc), m_index, hold_idx);
            end
            if (m_valid && m_ready) begin
                a = b + k[2:0];
                check($sformatf("%s_dat%0d", nm, k), m_data, rom[a]);
                check($sformatf("%s_idx%0d", nm, k), m_index, k);
                check($sformatf("%s_last%0d", nm, k), m_last, (k == l - 1));
                k++;
                last_hs = cyc;
            end
            stalled  = m_valid && !m_ready;
            hold_dat = m_data;
            hold_idx = m_index;
            if (done) begin
                done_cyc = cyc;
                check({nm, "_busy_at_done"}, busy, 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        exp_done = (l == 0) ? 0 : last_hs + 1;
        check({nm, "_beats"}, k, l);
        check({nm, "_done_cyc"}, done_cyc, exp_done);
        check({nm, "_first_vld"}, first_vld, (l == 0) ? -1 : 2);
        @(negedge clk);
        check({nm, "_done_pulse_end"}, done, 0);
        check({nm, "_idle_busy"}, busy, 0);
        check({nm, "_idle_vld"}, m_valid, 0);
    endtask

    initial begin
        rom[0] = 32'h41633404; rom[1] = 32'h4048F5C3;
        rom[2] = 32'h41999B71; rom[3] = 32'h429678A0;
        rom[4] = 32'h3F800000; rom[5] = 32'hC0200000;
        rom[6] = 32'hBF000000; rom[7] = 32'h41EEC4D0;

        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vld", m_valid, 0);
        check("rst_dat", m_data, 0);
        check("rst_idx", m_index, 0);
        check("rst_addr", rom_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(3'd0, 4'd8, 0, "sweep");
        run_burst(3'd6, 4'd4, 0, "wrap");
        check("wrap_naddr", nrec, 4);
        check("wrap_a0", addr_log[0], 6);
        check("wrap_a1", addr_log[1], 7);
        check("wrap_a2", addr_log[2], 0);
        check("wrap_a3", addr_log[3], 1);
        run_burst(3'd0, 4'd8, 1, "bp");
        run_burst(3'd5, 4'd0, 0, "len0");
        run_burst(3'd1, 4'd8, 2, "ignore");

        // Reset in the middle of a burst
        @(posedge clk); #1;
        start = 1'b1; base_addr = 3'd0; len = 4'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready && m_index == 4'd3) break;
        end
        check("mid_beat3_seen", m_index, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("mid_rst_vld", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dat", m_data, 0);
        check("mid_rst_idx", m_index, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_addr", rom_addr, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no_spurious_busy%0d", i), busy, 0);
            check($sformatf("no_spurious_vld%0d", i), m_valid, 0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        run_burst(3'd2, 4'd2, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
